mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have ports: clk_i  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have ports: rst_i  input  1  reset; synchronous, active-low.
REQ-003 The block SHALL have ports: RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i  input  1 each  control bits from the EX/MEM register.
REQ-004 The block SHALL have ports: ALU_data_i  input  32  memory address or ALU result; writeData_i  input  32  store data; RDaddr_i  input  5  destination register.
REQ-005 The block SHALL have ports: mem_req_o  output  1; mem_we_o  output  1; mem_addr_o  output  32; mem_wdata_o  output  32  data-memory request.
REQ-006 The block SHALL have ports: mem_ack_i  input  1  request accepted/complete; mem_rdata_i  input  32  read data, valid with mem_ack_i.
REQ-007 The block SHALL have ports: stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
REQ-008 The block SHALL have ports: RegWrite_o, Mem2Reg_o  output  1 each; ALU_data_o, readData_o  output  32 each; RDaddr_o  output  5  MEM/WB register outputs.
REQ-009 The block SHALL have port err_o  output  1  access-timeout pulse; tied 0 when MEM_TIMEOUT_EN is undefined.

Function
REQ-010 The FSM SHALL have states IDLE, REQ and DONE.
REQ-011 In IDLE with MemRead_i=0 and MemWrite_i=0, the block SHALL set stall_o=0 and latch all MEM/WB outputs from inputs at the clock edge (1-cycle latency), with readData_o <= 0.
REQ-012 In IDLE with MemRead_i=1 or MemWrite_i=1, the block SHALL set stall_o=1 combinationally and go to REQ.
REQ-013 In REQ, the block SHALL hold mem_req_o=1, mem_addr_o=ALU_data_i and mem_wdata_o=writeData_i; these SHALL be stable until mem_ack_i=1.
REQ-014 mem_we_o SHALL equal MemWrite_i in REQ; when MemRead_i and MemWrite_i are both 1, the block SHALL perform a write only.
REQ-015 In REQ with mem_ack_i=1, the block SHALL capture mem_rdata_i into an internal register (reads only) and go to DONE; otherwise it SHALL stay in REQ.
REQ-016 stall_o SHALL be 1 in IDLE-with-access and in REQ, and 0 in DONE.
REQ-017 In DONE, the block SHALL latch the MEM/WB outputs from inputs, with readData_o <= captured data (0 for stores), and go to IDLE.
REQ-018 While stall_o=1, MEM/WB SHALL latch a bubble: RegWrite_o=0, Mem2Reg_o=0, RDaddr_o=0, ALU_data_o=0, readData_o=0.
REQ-019 mem_req_o SHALL be 0 in IDLE and DONE, and mem_ack_i SHALL be ignored outside REQ.
REQ-020 Back-to-back memory instructions SHALL each pass IDLE->REQ->DONE, with no request issued twice for one instruction.
REQ-021 A memory access with ack in the first REQ cycle SHALL occupy 3 cycles (IDLE, REQ, DONE); each additional wait cycle SHALL add 1.
REQ-022 Zero_i SHALL NOT be an input; branch resolution is outside this block.

Reset
REQ-023 On a clock edge with rst_i=0, the block SHALL set state=IDLE and all registered outputs to 0, and clear the captured-data register and timeout counter.
REQ-024 A reset asserted in REQ SHALL drop mem_req_o in the following cycle, with no retry after reset release.
REQ-025 stall_o SHALL be 0 while rst_i=0.

Configuration
REQ-026 When MEM_TIMEOUT_EN is defined, a 4-bit counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-027 When MEM_TIMEOUT_EN is defined and the counter reaches 15 without ack, the block SHALL go to DONE, pulse err_o=1 for that one cycle, and force RegWrite_o=0 for that instruction in DONE.
REQ-028 An ack arriving on the same cycle the count reaches 15 SHALL win: normal completion, no err_o.
REQ-029 When MEM_TIMEOUT_EN is undefined, REQ SHALL wait indefinitely, with no counter logic and err_o=0.

Verification
REQ-030 The bench SHALL cover: ALU op RegWrite_i=1, RDaddr_i=5, ALU_data_i=32'h10 -> next cycle RegWrite_o=1, RDaddr_o=5, ALU_data_o=32'h10, stall_o=0 throughout.
REQ-031 The bench SHALL cover: load addr 32'h40, mem_ack_i on the 3rd REQ cycle with mem_rdata_i=32'hCAFE0001 -> stall_o high 4 cycles, mem_req_o high 3 cycles, then readData_o=32'hCAFE0001, Mem2Reg_o=1.
REQ-032 The bench SHALL cover: store with MemRead_i=MemWrite_i=1, writeData_i=32'h55 -> mem_we_o=1, mem_wdata_o=32'h55, readData_o=0.
REQ-033 The bench SHALL cover: load followed by store, ack immediate -> exactly two mem_req_o cycles, 6 total cycles, and bubbles on MEM/WB during stalls.
REQ-034 The bench SHALL cover: rst_i=0 during REQ -> next cycle mem_req_o=0, all outputs 0, state IDLE, and no request after release until a new access is presented.
REQ-035 The bench SHALL cover: with MEM_TIMEOUT_EN defined and no ack -> err_o single pulse, RegWrite_o=0, and stall released after 15 REQ cycles.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues a handshaked data-memory access, stalls the front end
// until it completes, and drives the MEM/WB register. `MEM_TIMEOUT_EN adds an access timeout.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        Mem2Reg_i,
    input  logic [31:0] ALU_data_i,
    input  logic [31:0] writeData_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        Mem2Reg_o,
    output logic [31:0] ALU_data_o,
    output logic [31:0] readData_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        regwrite_q, mem2reg_q;
    logic [31:0] alu_q, readdata_q;
    logic [4:0]  rd_q;
    logic        access;
    logic        err_q;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       err_d;
`endif

    assign access  = MemRead_i | MemWrite_i;
    assign stall_o = rst_i & (((state_q == IDLE) & access) | (state_q == REQ));

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_req_o & MemWrite_i;
    assign mem_addr_o  = mem_req_o ? ALU_data_i : '0;
    assign mem_wdata_o = mem_req_o ? writeData_i : '0;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = REQ;
                    rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                // An ack always beats the timeout, even on the cycle the count would expire.
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (MemRead_i && !MemWrite_i)
                        rdata_d = mem_rdata_i;
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'd15) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            regwrite_q <= 1'b0;
            mem2reg_q  <= 1'b0;
            alu_q      <= '0;
            readdata_q <= '0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (stall_o) begin
                regwrite_q <= 1'b0;
                mem2reg_q  <= 1'b0;
                alu_q      <= '0;
                readdata_q <= '0;
                rd_q       <= '0;
            end else begin
                // err_q is only ever high during DONE, marking a timed-out access.
                regwrite_q <= RegWrite_i & ~err_q;
                mem2reg_q  <= Mem2Reg_i;
                alu_q      <= ALU_data_i;
                readdata_q <= (state_q == DONE) ? rdata_q : '0;
                rd_q       <= RDaddr_i;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign err_o      = err_q;
    assign RegWrite_o = regwrite_q;
    assign Mem2Reg_o  = mem2reg_q;
    assign ALU_data_o = alu_q;
    assign readData_o = readdata_q;
    assign RDaddr_o   = rd_q;

endmodule
